// File: rtl/encoder_4x2_reg.sv
// encoder_4x2_reg: registered 4-to-2 encoder with valid/ready skid-free handshake and saturating error counter; define PRIO_ENC_EN to priority-encode multi-hot input
module encoder_4x2_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       code,
  output logic             err,
  output logic             vld,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d, enc_code;
  logic             err_q, err_d, enc_err;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;
  // encode the request lines; zero input is always an error
  always_comb begin
`ifdef PRIO_ENC_EN
    enc_code = i[3] ? 2'd3 : i[2] ? 2'd2 : i[1] ? 2'd1 : 2'd0;
    enc_err  = i == 4'b0000;
`else
    enc_code = i == 4'b1000 ? 2'd3 : i == 4'b0100 ? 2'd2 : i == 4'b0010 ? 2'd1 : 2'd0;
    enc_err  = !$onehot(i);
`endif
  end
  // handshake and next-state: a full register can refill in the same cycle it drains
  always_comb begin
    in_ready = rst_n && (state_q == EMPTY || out_ready);
    in_xfer  = in_valid && in_ready;
    out_xfer = state_q == FULL && out_ready;
    state_d  = in_xfer ? FULL : out_xfer ? EMPTY : state_q;
    code_d   = in_xfer ? enc_code : code_q;
    err_d    = in_xfer ? enc_err : err_q;
    cnt_d    = (in_xfer && enc_err && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, held word and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      code_q  <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign vld     = state_q == FULL;
  assign code    = code_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
endmodule

// File: tb/tb_encoder_4x2_reg.sv
// tb_encoder_4x2_reg: scoreboard bench for encoder_4x2_reg (default width and CNT_W=2 instances)
module tb_encoder_4x2_reg;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] i = 4'b0000;
  logic       in_ready, vld, err, in_ready2, vld2, err2;
  logic [1:0] code, code2, err_cnt2;
  logic [7:0] err_cnt;
  int         vecs = 0, miss = 0;
  logic       full_m = 1'b0;
  int         cnt8 = 0, cnt2 = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  encoder_4x2_reg dut (.clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .err(err), .vld(vld), .out_ready(out_ready), .err_cnt(err_cnt));
  encoder_4x2_reg #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .i(i), .in_valid(in_valid), .in_ready(in_ready2),
    .code(code2), .err(err2), .vld(vld2), .out_ready(out_ready), .err_cnt(err_cnt2));

  function automatic logic [2:0] enc(input logic [3:0] v);
    int n = 0;
    logic [1:0] hi = 2'd0;
    for (int k = 0; k < 4; k++) if (v[k]) begin n++; hi = 2'(k); end
`ifdef PRIO_ENC_EN
    return n == 0 ? 3'b001 : {hi, 1'b0};
`else
    return n == 1 ? {hi, 1'b0} : 3'b001;
`endif
  endfunction

  task automatic model_reset();
    full_m = 1'b0; exp_q.delete(); cnt8 = 0; cnt2 = 0;
  endtask

  // update the model for the current inputs, then cross one rising edge
  task automatic advance();
    logic ix, ox;
    logic [2:0] e;
    ix = in_valid && (!full_m || out_ready);
    ox = full_m && out_ready;
    e = enc(i);
    if (ox) void'(exp_q.pop_front());
    if (ix) begin
      exp_q.push_back(e);
      if (e[0]) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
    end
    full_m = ix || (full_m && !ox);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    vecs++;
    if (vld !== 1'b0 || code !== 2'd0 || err !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b0 || vld2 !== 1'b0 || in_ready2 !== 1'b0) begin
      miss++; $display("FAIL reset: vld=%b code=%0d err=%b cnt=%0d in_ready=%b vld2=%b rdy2=%b, want all 0", vld, code, err, err_cnt, in_ready, vld2, in_ready2);
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_onehot();
    logic [3:0] iv[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic       vv[6] = '{1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      i = iv[k]; in_valid = vv[k]; out_ready = 1'b1;
      @(negedge clk);
      vecs++;
      if (vld !== full_m || in_ready !== 1'b1) begin miss++; $display("FAIL onehot_hs[%0d]: vld=%b in_ready=%b want %b 1", k, vld, in_ready, full_m); end
      if (full_m) begin
        vecs++;
        if ({code, err} !== exp_q[0] || code !== 2'(k - 1)) begin miss++; $display("FAIL onehot_word[%0d]: code=%0d err=%b want code=%0d err=%b", k, code, err, exp_q[0][2:1], exp_q[0][0]); end
      end
      vecs++;
      if (err_cnt !== 8'd0) begin miss++; $display("FAIL onehot_cnt[%0d]: err_cnt=%0d want 0", k, err_cnt); end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] iv[7] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic       vv[7] = '{1, 1, 1, 1, 1, 0, 0};
    logic       rv[7] = '{0, 0, 0, 0, 1, 1, 1};
    for (int k = 0; k < 7; k++) begin
      i = iv[k]; in_valid = vv[k]; out_ready = rv[k];
      @(negedge clk);
      vecs++;
      if (vld !== full_m || in_ready !== (!full_m || out_ready)) begin miss++; $display("FAIL bp_hs[%0d]: vld=%b in_ready=%b want %b %b", k, vld, in_ready, full_m, !full_m || out_ready); end
      if (full_m) begin
        vecs++;
        if ({code, err} !== exp_q[0]) begin miss++; $display("FAIL bp_word[%0d]: code=%0d err=%b want code=%0d err=%b", k, code, err, exp_q[0][2:1], exp_q[0][0]); end
      end
      advance();
    end
  endtask

  task automatic test_errors();
    logic [3:0] iv[4] = '{4'b0000, 4'b1100, 4'b0000, 4'b0000};
    logic       vv[4] = '{1, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      i = iv[k]; in_valid = vv[k]; out_ready = 1'b1;
      @(negedge clk);
      vecs++;
      if (vld !== full_m) begin miss++; $display("FAIL err_vld[%0d]: vld=%b want %b", k, vld, full_m); end
      if (full_m) begin
        vecs++;
        if ({code, err} !== exp_q[0]) begin miss++; $display("FAIL err_word[%0d]: code=%0d err=%b want code=%0d err=%b", k, code, err, exp_q[0][2:1], exp_q[0][0]); end
      end
      vecs++;
      if (err_cnt !== 8'(cnt8) || err_cnt2 !== 2'(cnt2)) begin miss++; $display("FAIL err_cnt[%0d]: cnt=%0d cnt2=%0d want %0d %0d", k, err_cnt, err_cnt2, cnt8, cnt2); end
      advance();
    end
  endtask

  task automatic test_saturate();
    logic [1:0] sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0; #1 model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      if (full_m) begin
        vecs++;
        if ({code2, err2} !== exp_q[0]) begin miss++; $display("FAIL sat_word[%0d]: code=%0d err=%b want 0 1", k, code2, err2); end
      end
      advance();
      vecs++;
      if (err_cnt2 !== sat[k] || err_cnt2 !== 2'(cnt2) || err_cnt !== 8'(cnt8)) begin miss++; $display("FAIL sat_cnt[%0d]: cnt2=%0d cnt=%0d want %0d %0d", k, err_cnt2, err_cnt, sat[k], cnt8); end
    end
    in_valid = 1'b0; advance();
  endtask

  task automatic test_reset_mid();
    i = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    advance();
    vecs++;
    if (vld !== 1'b1 || code !== 2'd1 || err !== 1'b0) begin miss++; $display("FAIL rmid_load: vld=%b code=%0d err=%b want 1 1 0", vld, code, err); end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (vld !== 1'b0 || code !== 2'd0 || err !== 1'b0 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0 || in_ready !== 1'b0) begin
      miss++; $display("FAIL rmid_async: vld=%b code=%0d err=%b cnt=%0d cnt2=%0d in_ready=%b want all 0", vld, code, err, err_cnt, err_cnt2, in_ready);
    end
    model_reset();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (vld !== 1'b0 || in_ready !== 1'b1) begin miss++; $display("FAIL rmid_after[%0d]: vld=%b in_ready=%b want 0 1", k, vld, in_ready); end
      advance();
    end
  endtask

  task automatic test_idle();
    int c0;
    i = 4'b0000; in_valid = 1'b1; out_ready = 1'b1; advance();
    in_valid = 1'b0; advance();
    c0 = cnt8;
    for (int k = 0; k < 10; k++) begin
      i = 4'($urandom_range(0, 15)); out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      vecs++;
      if (vld !== 1'b0 || err_cnt !== 8'(c0)) begin miss++; $display("FAIL idle[%0d]: vld=%b cnt=%0d want 0 %0d", k, vld, err_cnt, c0); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 80; k++) begin
      i = 4'($urandom_range(0, 15)); in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vecs++;
      if (vld !== full_m || in_ready !== (!full_m || out_ready)) begin miss++; $display("FAIL b2b_hs[%0d]: vld=%b in_ready=%b want %b %b", k, vld, in_ready, full_m, !full_m || out_ready); end
      if (full_m) begin
        vecs++;
        if ({code, err} !== exp_q[0] || {code2, err2} !== exp_q[0]) begin miss++; $display("FAIL b2b_word[%0d]: code=%0d err=%b want code=%0d err=%b", k, code, err, exp_q[0][2:1], exp_q[0][0]); end
      end
      vecs++;
      if (err_cnt !== 8'(cnt8) || err_cnt2 !== 2'(cnt2)) begin miss++; $display("FAIL b2b_cnt[%0d]: cnt=%0d cnt2=%0d want %0d %0d", k, err_cnt, err_cnt2, cnt8, cnt2); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_backpressure();
    test_errors();
    test_saturate();
    test_reset_mid();
    test_idle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
